// File: rtl/alu_issue_stage_pkg.sv
// Shared constants, opcodes and pipeline tag type for the 16-bit ALU issue path.
// The ALU and the decoder use the same package.
package misc_v_alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int REG_W  = 3;
  localparam int IMM_W  = 8;

  typedef enum logic [OP_W-1:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic             write;
    logic [REG_W-1:0] dest;
  } stage_tag_t;

  // Shift amounts are unsigned, so shifts zero-extend; everything else sign-extends.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                   input logic [OP_W-1:0]  op);
    if (op == ALU_SHL || op == ALU_SHR)
      return {{(DATA_W-IMM_W){1'b0}}, imm};
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle between the decoder (master) and the issue stage (slave), including the
// ALU operand/result side and the writeback tags.
interface alu_issue_stage_if;
  import misc_v_alu_pkg::*;

  logic              InValid;
  logic              InReady;
  logic [OP_W-1:0]   InOp;
  logic [REG_W-1:0]  InSrcA;
  logic [REG_W-1:0]  InSrcB;
  logic [REG_W-1:0]  InDest;
  logic              InWrite;
  logic              InUseImm;
  logic [IMM_W-1:0]  InImm;
  logic [DATA_W-1:0] InRegA;
  logic [DATA_W-1:0] InRegB;
  logic [DATA_W-1:0] ALUResult;
  logic              ALUZero;
  logic [DATA_W-1:0] FirstInput;
  logic [DATA_W-1:0] SecondInput;
  logic [OP_W-1:0]   ALUOp;
  logic              OutValid;
  logic              ResultValid;
  logic [REG_W-1:0]  ResultDest;
  logic              ResultWrite;
  logic [DATA_W-1:0] ResultData;
  logic              ResultZero;
  logic [15:0]       StallCount;

  modport master (
    output InValid, InOp, InSrcA, InSrcB, InDest, InWrite, InUseImm, InImm,
           InRegA, InRegB, ALUResult, ALUZero,
    input  InReady, FirstInput, SecondInput, ALUOp, OutValid, ResultValid,
           ResultDest, ResultWrite, ResultData, ResultZero, StallCount
  );

  modport slave (
    input  InValid, InOp, InSrcA, InSrcB, InDest, InWrite, InUseImm, InImm,
           InRegA, InRegB, ALUResult, ALUZero,
    output InReady, FirstInput, SecondInput, ALUOp, OutValid, ResultValid,
           ResultDest, ResultWrite, ResultData, ResultZero, StallCount
  );

endinterface

// File: rtl/alu_issue_stage_hazard_detect.sv
// RAW hazard comparators: a stage-1 producer forces a stall, a stage-2 producer
// is forwarded from ALUResult. Stage-1 matches take priority.
module alu_hazard_detect
  import misc_v_alu_pkg::*;
(
  input  stage_tag_t       s1_tag_i,
  input  stage_tag_t       s2_tag_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic             use_imm_i,
  output logic             stall_o,
  output logic             fwd_a_o,
  output logic             fwd_b_o
);

  logic [REG_W-1:0] src [2];
  logic [1:0]       used;
  logic [1:0]       hit1;
  logic [1:0]       hit2;

  assign src[0] = src_a_i;
  assign src[1] = src_b_i;
  assign used   = {~use_imm_i, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign hit1[gi] = used[gi] & s1_tag_i.valid & s1_tag_i.write & (s1_tag_i.dest == src[gi]);
      assign hit2[gi] = used[gi] & s2_tag_i.valid & s2_tag_i.write & (s2_tag_i.dest == src[gi]);
    end
  endgenerate

  assign stall_o = |hit1;
  assign fwd_a_o = hit2[0] & ~hit1[0];
  assign fwd_b_o = hit2[1] & ~hit1[1];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the registered ALU: operand select/forwarding, hazard
// stall, stage-1 operand register, stage-2 writeback tag and stall counter.
module alu_issue_stage
  import misc_v_alu_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  alu_issue_stage_if.slave bus
);

  stage_tag_t        s1_tag_q, s1_tag_d;
  stage_tag_t        s2_tag_q, s2_tag_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              stall;
  logic              fwd_a;
  logic              fwd_b;
  logic              in_ready;

  alu_hazard_detect u_hazard (
    .s1_tag_i  (s1_tag_q),
    .s2_tag_i  (s2_tag_q),
    .src_a_i   (bus.InSrcA),
    .src_b_i   (bus.InSrcB),
    .use_imm_i (bus.InUseImm),
    .stall_o   (stall),
    .fwd_a_o   (fwd_a),
    .fwd_b_o   (fwd_b)
  );

  assign in_ready = ~Reset & ~Flush & ~stall;

  always_comb begin
    s1_tag_d    = '0;
    s2_tag_d    = s1_tag_q;
    op_d        = '0;
    a_d         = '0;
    b_d         = '0;
    stall_cnt_d = stall_cnt_q;
    if (Flush) begin
      s2_tag_d = '0;
    end else if (bus.InValid && in_ready) begin
      s1_tag_d.valid = 1'b1;
      s1_tag_d.write = bus.InWrite;
      s1_tag_d.dest  = bus.InDest;
      op_d           = bus.InOp;
      a_d            = fwd_a ? bus.ALUResult : bus.InRegA;
      if (bus.InUseImm)
        b_d = extend_imm(bus.InImm, bus.InOp);
      else
        b_d = fwd_b ? bus.ALUResult : bus.InRegB;
    end else if (bus.InValid && stall_cnt_q != 16'hFFFF) begin
      // Not flushing and not accepted: this cycle is a hazard bubble.
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.InReady     = in_ready;
  assign bus.FirstInput  = a_q;
  assign bus.SecondInput = b_q;
  assign bus.ALUOp       = op_q;
  assign bus.OutValid    = s1_tag_q.valid;
  assign bus.ResultValid = s2_tag_q.valid;
  assign bus.ResultDest  = s2_tag_q.dest;
  assign bus.ResultWrite = s2_tag_q.write;
  assign bus.ResultData  = bus.ALUResult;
  assign bus.ResultZero  = bus.ALUZero;
  assign bus.StallCount  = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: registered ALU and register file around the stage,
// checked against an in-order architectural model of every issued op.
module tb_alu_issue_stage;
  import misc_v_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .CLK   (clk),
    .Reset (rst),
    .Flush (flush),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return a << b[3:0];
      3'd6:    return a >> b[3:0];
      3'd7:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] imm_value(input logic [7:0] imm, input logic [2:0] op);
    if (op == 3'd5 || op == 3'd6) return {8'h00, imm};
    return {{8{imm[7]}}, imm};
  endfunction

  // Environment: register file with writeback, and a one-cycle registered ALU.
  logic [15:0] env_rf [8];
  logic [15:0] alu_q = 16'h0000;

  always_comb begin
    bus.InRegA = env_rf[bus.InSrcA];
    bus.InRegB = env_rf[bus.InSrcB];
  end

  always @(posedge clk) begin
    alu_q <= alu_fn(bus.ALUOp, bus.FirstInput, bus.SecondInput);
    if (!rst && !flush && bus.ResultValid && bus.ResultWrite)
      env_rf[bus.ResultDest] <= bus.ResultData;
  end

  assign bus.ALUResult = alu_q;
  assign bus.ALUZero   = (alu_q == 16'h0000);

  // Reference model: ops stamped with their accept cycle, results computed in program order.
  typedef struct {
    int          cyc;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  dest;
    logic        wr;
  } op_t;

  op_t         q [$];
  op_t         m_s1, m_s2, m_new;
  bit          s1v, s2v, exp_ready;
  logic [15:0] spec_rf [8];
  logic [15:0] arch_rf [8];
  int          ncyc      = 0;
  int          stall_exp = 0;

  always @(negedge clk) begin
    s1v = 1'b0;
    s2v = 1'b0;
    foreach (q[i]) begin
      if (q[i].cyc == ncyc - 1) begin m_s1 = q[i]; s1v = 1'b1; end
      if (q[i].cyc == ncyc - 2) begin m_s2 = q[i]; s2v = 1'b1; end
    end
    check_eq("out_valid", bus.OutValid, s1v);
    check_eq("alu_op", bus.ALUOp, s1v ? m_s1.op : 3'd0);
    check_eq("first_in", bus.FirstInput, s1v ? m_s1.a : 16'd0);
    check_eq("second_in", bus.SecondInput, s1v ? m_s1.b : 16'd0);
    check_eq("res_valid", bus.ResultValid, s2v);
    if (s2v) begin
      check_eq("res_dest", bus.ResultDest, m_s2.dest);
      check_eq("res_write", bus.ResultWrite, m_s2.wr);
      check_eq("res_data", bus.ResultData, m_s2.res);
      check_eq("res_zero", bus.ResultZero, m_s2.res == 16'd0);
    end
    check_eq("stall_cnt", bus.StallCount, stall_exp);
    exp_ready = !rst && !flush &&
                !(s1v && m_s1.wr && (m_s1.dest == bus.InSrcA ||
                                     (!bus.InUseImm && m_s1.dest == bus.InSrcB)));
    check_eq("in_ready", bus.InReady, exp_ready);

    // Advance the model to the state after the coming rising edge.
    if (rst || flush) begin
      q.delete();
      spec_rf = arch_rf;
      if (rst) stall_exp = 0;
    end else begin
      if (s2v) begin
        if (m_s2.wr) arch_rf[m_s2.dest] = m_s2.res;
        void'(q.pop_front());
      end
      if (bus.InValid && exp_ready) begin
        m_new.cyc  = ncyc;
        m_new.op   = bus.InOp;
        m_new.a    = spec_rf[bus.InSrcA];
        m_new.b    = bus.InUseImm ? imm_value(bus.InImm, bus.InOp) : spec_rf[bus.InSrcB];
        m_new.res  = alu_fn(m_new.op, m_new.a, m_new.b);
        m_new.dest = bus.InDest;
        m_new.wr   = bus.InWrite;
        if (m_new.wr) spec_rf[m_new.dest] = m_new.res;
        q.push_back(m_new);
      end else if (bus.InValid && stall_exp < 65535) begin
        stall_exp++;
      end
    end
    ncyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.InValid = 1'b0;
  endtask

  // Present an op until accepted; waits returns the number of stall cycles seen.
  task automatic issue(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] d, input logic wr, input logic ui,
                       input logic [7:0] imm, output int waits);
    logic rdy;
    rdy = 1'b0;
    bus.InValid  = 1'b1;
    bus.InOp     = op;
    bus.InSrcA   = sa;
    bus.InSrcB   = sb;
    bus.InDest   = d;
    bus.InWrite  = wr;
    bus.InUseImm = ui;
    bus.InImm    = imm;
    waits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rdy = bus.InReady;
      step();
      if (rdy) break;
      waits++;
    end
    check_eq("issue_accept", rdy, 1'b1);
    bus.InValid = 1'b0;
  endtask

  int w;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    bus.InValid = 1'b1; bus.InOp = 3'd1; bus.InSrcA = 3'd3; bus.InSrcB = 3'd4;
    bus.InDest = 3'd2; bus.InWrite = 1'b1; bus.InUseImm = 1'b0; bus.InImm = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] v;
      v = (i == 3) ? 16'd5 : (i == 4) ? 16'd7 : (i == 5) ? 16'd2 : (i == 6) ? 16'd3 : 16'd0;
      env_rf[i] <= v;
      arch_rf[i] = v;
      spec_rf[i] = v;
    end

    // Reset with a pending op: everything held at zero, not ready.
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.InReady, 1'b0);
    check_eq("rst_outvalid", bus.OutValid, 1'b0);
    check_eq("rst_resvalid", bus.ResultValid, 1'b0);
    check_eq("rst_aluop", bus.ALUOp, 3'd0);
    check_eq("rst_first", bus.FirstInput, 16'd0);
    check_eq("rst_stall", bus.StallCount, 16'd0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check_eq("rel_ready", bus.InReady, 1'b1);

    // ADD 5+7 -> r2
    step();
    issue(3'd1, 3'd3, 3'd4, 3'd2, 1'b1, 1'b0, 8'h00, w);
    @(negedge clk);
    check_eq("add_first", bus.FirstInput, 16'd5);
    check_eq("add_second", bus.SecondInput, 16'd7);
    check_eq("add_op", bus.ALUOp, 3'd1);
    @(negedge clk);
    check_eq("add_resvalid", bus.ResultValid, 1'b1);
    check_eq("add_dest", bus.ResultDest, 3'd2);
    check_eq("add_data", bus.ResultData, 16'd12);

    // Immediate extension: signed for SUB, unsigned for SHL
    step();
    issue(3'd2, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 8'hFF, w);
    @(negedge clk);
    check_eq("imm_sext", bus.SecondInput, 16'hFFFF);
    step();
    issue(3'd5, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 8'h82, w);
    @(negedge clk);
    check_eq("imm_zext", bus.SecondInput, 16'h0082);

    // Back-to-back dependency: one stall, then forwarded operand
    step();
    issue(3'd1, 3'd5, 3'd6, 3'd1, 1'b1, 1'b0, 8'h00, w);
    issue(3'd2, 3'd1, 3'd4, 3'd7, 1'b1, 1'b0, 8'h00, w);
    check_eq("dep_waits", w, 1);
    @(negedge clk);
    check_eq("dep_stallcnt", bus.StallCount, 16'd1);
    check_eq("dep_fwd_a", bus.FirstInput, 16'd5);

    // Distance-two dependency on B: forwarded without stalling
    step();
    issue(3'd1, 3'd3, 3'd4, 3'd1, 1'b1, 1'b0, 8'h00, w);
    issue(3'd3, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, 8'h00, w);
    issue(3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 8'h00, w);
    check_eq("fwdb_waits", w, 0);
    @(negedge clk);
    check_eq("fwdb_second", bus.SecondInput, 16'd12);
    check_eq("fwdb_stallcnt", bus.StallCount, 16'd1);

    // Flush with two ops in flight
    step();
    issue(3'd7, 3'd3, 3'd4, 3'd0, 1'b1, 1'b0, 8'h00, w);
    issue(3'd4, 3'd5, 3'd6, 3'd3, 1'b1, 1'b0, 8'h00, w);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_ready", bus.InReady, 1'b0);
    step();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("flush_outvalid", bus.OutValid, 1'b0);
      check_eq("flush_resvalid", bus.ResultValid, 1'b0);
      check_eq("flush_aluop", bus.ALUOp, 3'd0);
    end

    // Randomized traffic with occasional flush/reset, checked by the model each cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      bus.InValid  = ($urandom_range(0, 9) < 7);
      bus.InOp     = 3'($urandom_range(0, 7));
      bus.InSrcA   = 3'($urandom_range(0, 7));
      bus.InSrcB   = 3'($urandom_range(0, 7));
      bus.InDest   = 3'($urandom_range(0, 7));
      bus.InWrite  = ($urandom_range(0, 3) != 0);
      bus.InUseImm = ($urandom_range(0, 3) == 0);
      bus.InImm    = 8'($urandom_range(0, 255));
    end
    step();
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
